// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bundle for the round-robin output arbiter: the request and
// packed data inputs plus the registered grant/channel outputs.
interface mux_rr_arbiter_if #(
  parameter int NREQ        = 4,
  parameter int NBITS_DATA  = 2,
  parameter int HOLD_CYCLES = 3
);
  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

  logic [NREQ-1:0]            req;
  logic [NREQ*NBITS_DATA-1:0] data_in;
  logic [NREQ-1:0]            grant;
  logic                       grant_valid;
  logic [IDX_W-1:0]           grant_idx;
  logic [NBITS_DATA-1:0]      data_out;
  logic [CNT_W-1:0]           hold_cnt;

  // Requesters drive req/data_in and watch the grant and channel.
  modport master (
    output req, data_in,
    input  grant, grant_valid, grant_idx, data_out, hold_cnt
  );

  // The arbiter consumes requests and owns the channel outputs.
  modport slave (
    input  req, data_in,
    output grant, grant_valid, grant_idx, data_out, hold_cnt
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one narrow registered output channel among
// NREQ requesters. A grant lasts at most HOLD_CYCLES cycles and is always
// followed by at least one idle cycle (break-before-make). Every output is a
// register, so downstream muxes can drive board pins straight from it.
// NREQ must be a power of two (>=2) so pointer arithmetic wraps naturally.
module mux_rr_arbiter #(
  parameter int NREQ        = 4,
  parameter int NBITS_DATA  = 2,
  parameter int HOLD_CYCLES = 3
) (
  input logic              clk_2,
  input logic              reset_n,
  mux_rr_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  logic [NREQ-1:0]       r_grant;
  logic                  r_grant_valid;
  logic [IDX_W-1:0]      r_grant_idx;
  logic [IDX_W-1:0]      r_ptr;
  logic [NBITS_DATA-1:0] r_data;
  logic [CNT_W-1:0]      r_hold;

  logic [NBITS_DATA-1:0] w_slice [NREQ];
  logic [NREQ-1:0]       w_rot;
  logic [IDX_W-1:0]      w_off;
  logic [IDX_W-1:0]      w_sel;
  logic [IDX_W-1:0]      w_ptr_next;
  logic [NREQ-1:0]       w_sel_onehot;
  logic                  w_any;
  logic                  w_held_req;
  logic                  w_release;
  logic [NBITS_DATA-1:0] w_sel_data;
  logic [NBITS_DATA-1:0] w_held_data;

  // Per-requester lanes: data slices, and requests rotated so that lane 0 is
  // the requester the pointer currently favours.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign w_slice[gi] = bus.data_in[gi*NBITS_DATA +: NBITS_DATA];
      assign w_rot[gi]   = bus.req[r_ptr + IDX_W'(gi)];
    end
  endgenerate

  // Find the lowest set bit of the rotated request vector (offset from ptr).
  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = IDX_W'(i);
      end
    end
  end

  assign w_any        = |bus.req;
  assign w_sel        = r_ptr + w_off;
  assign w_ptr_next   = w_sel + IDX_W'(1);
  assign w_sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
  assign w_sel_data   = w_slice[w_sel];
  assign w_held_req   = bus.req[r_grant_idx];
  assign w_held_data  = w_slice[r_grant_idx];
  // A grant ends when its owner withdraws or the hold window is used up.
  assign w_release    = !w_held_req || (r_hold == '0);

  // Arbitration FSM: every channel output is loaded here, never decoded.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_ptr         <= '0;
      r_data        <= '0;
      r_hold        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state       <= ST_BUSY;
            r_grant       <= w_sel_onehot;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= w_sel;
            r_data        <= w_sel_data;
            r_hold        <= CNT_W'(HOLD_CYCLES - 1);
            r_ptr         <= w_ptr_next;
          end else begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_data        <= '0;
            r_hold        <= '0;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            // Index and pointer are kept so the last owner stays visible.
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_data        <= '0;
            r_hold        <= '0;
          end else begin
            r_hold        <= r_hold - CNT_W'(1);
            r_data        <= w_held_data;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_data        <= '0;
          r_hold        <= '0;
        end
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = r_grant_valid;
  assign bus.grant_idx   = r_grant_idx;
  assign bus.data_out    = r_data;
  assign bus.hold_cnt    = r_hold;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a reference model pushes expected
// outputs when stimulus is driven, a monitor pops and compares after each
// edge, and directed checks pin down the documented scenarios.
module tb_mux_rr_arbiter;
  localparam int NREQ = 4;
  localparam int NB   = 2;
  localparam int HOLD = 3;

  typedef struct packed {
    logic [3:0] grant;
    logic       valid;
    logic [1:0] idx;
    logic [1:0] data;
    logic [2:0] hold;
  } exp_t;

  logic clk_2   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_2 = ~clk_2;

  mux_rr_arbiter_if #(.NREQ(NREQ), .NBITS_DATA(NB), .HOLD_CYCLES(HOLD)) bus ();

  mux_rr_arbiter #(.NREQ(NREQ), .NBITS_DATA(NB), .HOLD_CYCLES(HOLD)) dut (
    .clk_2  (clk_2),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  // reference model state
  bit         m_busy;
  int         m_ptr, m_idx, m_hold;
  logic [3:0] m_grant;
  logic [1:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, bus.grant, 0);
    check({tag, "_valid"}, bus.grant_valid, 0);
    check({tag, "_idx"},   bus.grant_idx, 0);
    check({tag, "_data"},  bus.data_out, 0);
    check({tag, "_hold"},  bus.hold_cnt, 0);
  endtask

  function automatic void model_reset();
    m_busy = 0; m_ptr = 0; m_idx = 0; m_hold = 0; m_grant = '0; m_data = '0;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic [7:0] d);
    int k;
    k = -1;
    if (!m_busy) begin
      for (int o = 0; o < NREQ; o++) begin
        if (k < 0 && r[(m_ptr + o) % NREQ]) k = (m_ptr + o) % NREQ;
      end
      if (k >= 0) begin
        m_busy = 1; m_idx = k; m_grant = 4'(1 << k);
        m_data = d[k*NB +: NB]; m_hold = HOLD - 1; m_ptr = (k + 1) % NREQ;
      end else begin
        m_grant = '0; m_data = '0; m_hold = 0;
      end
    end else if (!r[m_idx] || m_hold == 0) begin
      m_busy = 0; m_grant = '0; m_data = '0; m_hold = 0;
    end else begin
      m_hold = m_hold - 1;
      m_data = d[m_idx*NB +: NB];
    end
  endfunction

  // Drive one cycle of stimulus, queue the model's prediction, return after the edge.
  task automatic cycle(input logic [3:0] r, input logic [7:0] d);
    exp_t e;
    @(negedge clk_2);
    bus.req     = r;
    bus.data_in = d;
    model_step(r, d);
    e.grant = m_grant;
    e.valid = m_busy;
    e.idx   = 2'(m_idx);
    e.data  = m_data;
    e.hold  = 3'(m_hold);
    sb_q.push_back(e);
    @(posedge clk_2);
    #2;
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic reset_pulse(input string tag);
    #1 reset_n = 1'b0;
    #1 check_zero({tag, "_async"});
    model_reset();
    @(posedge clk_2);
    #1 check_zero({tag, "_held"});
    #2 reset_n = 1'b1;
  endtask

  // Monitor: compare DUT against the oldest prediction after each edge.
  always @(posedge clk_2) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check("sb_grant", bus.grant,       mon_e.grant);
      check("sb_valid", bus.grant_valid, mon_e.valid);
      check("sb_idx",   bus.grant_idx,   mon_e.idx);
      check("sb_data",  bus.data_out,    mon_e.data);
      check("sb_hold",  bus.hold_cnt,    mon_e.hold);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] t2_grant [8];
    int         t2_hold  [8];
    t2_grant = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    t2_hold  = '{2, 1, 0, 0, 2, 1, 0, 0};

    bus.req     = 4'b1111;
    bus.data_in = 8'h00;
    model_reset();

    // 1. reset held with all requests high
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_2);
      #1 check_zero("t1_rst");
    end
    #2 reset_n = 1'b1;

    // 2. single requester, period 4
    for (int i = 0; i < 8; i++) begin
      cycle(4'b0001, 8'b0000_0011);
      check("t2_grant", bus.grant, t2_grant[i]);
      check("t2_hold", bus.hold_cnt, t2_hold[i]);
      $display("[TB] t2 cycle %0d grant=%b data=%b hold=%0d", i, bus.grant, bus.data_out, bus.hold_cnt);
    end

    // 3. all requesting after a mid-cycle reset: order 0,1,2,3,0
    reset_pulse("t3_rst");
    for (int i = 0; i < 20; i++) begin
      cycle(4'b1111, 8'hE4);
      if (i % 4 == 0) begin
        check("t3_idx", bus.grant_idx, (i / 4) % 4);
        check("t3_grant", bus.grant, 1 << ((i / 4) % 4));
      end else if (i % 4 == 3) begin
        check("t3_gap", bus.grant_valid, 0);
      end
      $display("[TB] t3 cycle %0d grant=%b idx=%0d data=%b", i, bus.grant, bus.grant_idx, bus.data_out);
    end

    // 4. pointer skip
    for (int i = 0; i < 8; i++) begin
      cycle(4'b0101, 8'hE4);
      if (i == 0) check("t4_skip2", bus.grant, 4'b0100);
      if (i == 4) check("t4_wrap0", bus.grant, 4'b0001);
      $display("[TB] t4 cycle %0d grant=%b idx=%0d", i, bus.grant, bus.grant_idx);
    end
    cycle(4'b1000, 8'hE4);
    check("t4_g3", bus.grant, 4'b1000);
    cycle(4'b0011, 8'hE4);
    check("t4_rel3", bus.grant_valid, 0);
    cycle(4'b0011, 8'hE4);
    check("t4_after3", bus.grant, 4'b0001);
    $display("[TB] t4 after grant 3 grant=%b", bus.grant);

    // 5. early release and one-cycle data latency
    cycle(4'b0000, 8'h00);
    cycle(4'b0000, 8'h00);
    cycle(4'b0010, 8'b0000_0100);
    check("t5_grant", bus.grant, 4'b0010);
    check("t5_data0", bus.data_out, 2'b01);
    cycle(4'b0010, 8'b0000_1000);
    check("t5_data1", bus.data_out, 2'b10);
    check("t5_hold1", bus.hold_cnt, 1);
    cycle(4'b0000, 8'b0000_1000);
    check("t5_rel_grant", bus.grant, 4'b0000);
    check("t5_rel_hold", bus.hold_cnt, 0);
    check("t5_rel_idx", bus.grant_idx, 1);
    $display("[TB] t5 release grant=%b idx=%0d hold=%0d", bus.grant, bus.grant_idx, bus.hold_cnt);

    // 6. reset during BUSY, then restart from ptr 0
    cycle(4'b1111, 8'hE4);
    check("t6_grant2", bus.grant, 4'b0100);
    cycle(4'b1111, 8'hE4);
    check("t6_hold1", bus.hold_cnt, 1);
    reset_pulse("t6_rst");
    cycle(4'b1111, 8'hE4);
    check("t6_restart", bus.grant, 4'b0001);
    $display("[TB] t6 restart grant=%b", bus.grant);

    // random traffic against the model, with occasional resets
    for (int i = 0; i < 300; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      cycle(r, 8'($urandom));
      if (i % 97 == 96) reset_pulse("rnd_rst");
    end
    $display("[TB] random phase done, queue depth %0d", sb_q.size());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and output sequencer that shares one narrow output channel among NREQ requesters, e.g. the LED[7:6] pair on the lab board, with each requester's data and request driven from SWI groups.
- Grants one requester at a time for a bounded hold window, then forces one idle cycle before the next grant (break-before-make).
- The channel data is registered, so a top-level mux can drive LED/SEG and the LCD debug signals directly from it.

Parameters:
- NREQ, 4: number of requesters. Must be ≥2 and a power of two.
- NBITS_DATA, 2: width of each requester's data slice and of data_out.
- HOLD_CYCLES, 3: maximum number of consecutive BUSY cycles per grant. Must be ≥1.

Ports:
- clk_2, input, 1: single clock. All state changes on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- req, input, NREQ: request vector. req[i]=1 means requester i wants the channel.
- data_in, input, NREQ*NBITS_DATA: packed data. Slice i is data_in[i*NBITS_DATA +: NBITS_DATA].
- grant, output, NREQ: one-hot grant, or all zero.
- grant_valid, output, 1: high while any grant is asserted.
- grant_idx, output, $clog2(NREQ): index of the current or last granted requester.
- data_out, output, NBITS_DATA: registered data of the granted requester. Zero when no grant.
- hold_cnt, output, $clog2(HOLD_CYCLES)+1: remaining BUSY cycles after the current one (debug, for the LCD).

Behaviour:
- Reset (reset_n=0, takes effect immediately, no clock needed):
  - state=IDLE
  - grant=0, grant_valid=0, grant_idx=0, data_out=0, hold_cnt=0
  - round-robin pointer ptr=0
- States: IDLE and BUSY.
- IDLE, at each edge:
  - If req==0: stay in IDLE, outputs remain at the zero values.
  - Otherwise select k = the first i with req[i]=1, searching ptr, ptr+1, … modulo NREQ.
  - Load state=BUSY, grant=1<<k, grant_valid=1, grant_idx=k, data_out=slice k, hold_cnt=HOLD_CYCLES-1, ptr=(k+1) mod NREQ.
- BUSY, at each edge:
  - If req[grant_idx]==0 or hold_cnt==0: go to IDLE. grant=0, grant_valid=0, data_out=0, hold_cnt=0. grant_idx and ptr are held.
  - Otherwise: hold_cnt decrements by 1 and data_out=slice grant_idx. Data changes therefore appear with exactly 1 cycle of latency.
- Timing consequences:
  - A grant lasts at most HOLD_CYCLES cycles.
  - Every grant is followed by at least one IDLE cycle.
  - Latency from req rising (sampled in IDLE) to grant is 1 edge.
- Requests from requesters other than the granted one are ignored during BUSY. They are considered at the next IDLE edge.
- The pointer advances only when a grant is issued, which gives fairness: with all req high, the grant order is 0,1,…,NREQ-1,0,…
- Outputs come from registers only. There is no combinational path from req or data_in to any output.
- Reset asserted during BUSY:
  - All outputs and ptr clear immediately.
  - After release, arbitration restarts from ptr=0 on the first edge with reset_n=1.
- An X or Z on req is not handled; the bench must drive clean values.

Test Plan (NREQ=4, NBITS_DATA=2, HOLD_CYCLES=3):
1. Reset: hold reset_n=0 with req=1111 -> grant=0000, grant_valid=0, data_out=00, grant_idx=0, hold_cnt=0. Drop reset_n asynchronously mid-cycle -> outputs clear before the next edge.
2. Single requester: req=0001, slice0=11 held -> grant=0001 and data_out=11 for 3 cycles (hold_cnt 2,1,0), then 1 cycle with grant=0000/data_out=00, then a regrant to 0001. The pattern repeats with period 4.
3. All requesting: req=1111 -> grants 0001,0010,0100,1000,0001, each lasting 3 cycles, separated by single idle cycles. grant_idx goes 0,1,2,3,0.
4. Pointer skip: after a grant to requester 0, set req=0101 -> next grant=0100 (idx 2), then 0001. After a grant to 3 with req=0011 -> next grant=0001.
5. Early release and data latency: grant to 1 with slice1=01. Change slice1 to 10 in BUSY cycle 1 -> data_out=10 from the next edge. Drop req[1] in BUSY cycle 2 -> IDLE at that edge, grant=0000, hold_cnt=0.
6. Reset mid-BUSY: during a grant to 2 (hold_cnt=1), pulse reset_n low -> all outputs 0 immediately. After release with req=1111 -> the first grant is 0001 (ptr restarted at 0).
